// File: rtl/vga_draw_arbiter_if.sv
// rtl/vga_draw_arbiter_if.sv - request/grant, engine and VGA pixel signals of the draw arbiter
//
// Ports (signals bundled here):
//   req        requester level draw requests
//   grant      one-hot current owner, finished / timeout one-cycle end pulses
//   eng_*      per-engine reset, start, done and packed pixel streams
//   vga_*      muxed pixel port towards the VGA adapter
//   busy       arbiter not idle
// Modports: master = arbiter side, slave = requesters/engines/adapter side.
interface vga_draw_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   finished;
    logic [NREQ-1:0]   timeout;
    logic [NREQ-1:0]   eng_rst_n;
    logic [NREQ-1:0]   eng_start;
    logic [NREQ-1:0]   eng_done;
    logic [NREQ*8-1:0] eng_x;
    logic [NREQ*7-1:0] eng_y;
    logic [NREQ*3-1:0] eng_colour;
    logic [NREQ-1:0]   eng_plot;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [2:0]        vga_colour;
    logic              vga_plot;
    logic              busy;

    modport master (
        input  req, eng_done, eng_x, eng_y, eng_colour, eng_plot,
        output grant, finished, timeout, eng_rst_n, eng_start,
               vga_x, vga_y, vga_colour, vga_plot, busy
    );

    modport slave (
        output req, eng_done, eng_x, eng_y, eng_colour, eng_plot,
        input  grant, finished, timeout, eng_rst_n, eng_start,
               vga_x, vga_y, vga_colour, vga_plot, busy
    );
endinterface

// File: rtl/vga_draw_arbiter.sv
// rtl/vga_draw_arbiter.sv - round-robin arbiter sharing the VGA pixel port between drawing engines
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    vga_draw_arbiter_if.master (requests, engine handshakes, pixel streams, VGA port)
// Parameters:
//   NREQ         number of requester/engine pairs (2..8)
//   WDOG_CYCLES  RUN-cycle limit before an engine is aborted
// Optional feature macro: DRAW_ARB_WATCHDOG_EN (watchdog abort with timeout pulse).
module vga_draw_arbiter #(
    parameter int NREQ        = 3,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_draw_arbiter_if.master bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_RELEASE
    } state_t;

    state_t          state;
    logic [GW-1:0]   g;
    logic [GW-1:0]   ptr;
    logic [NREQ-1:0] grant_r;
    logic [NREQ-1:0] fin_r;
    logic [NREQ-1:0] rstn_r;
    logic [NREQ-1:0] start_r;
`ifdef DRAW_ARB_WATCHDOG_EN
    logic [NREQ-1:0] to_r;
    logic [15:0]     wdog_cnt;
`endif

    logic            sel_valid;
    logic [GW-1:0]   sel_idx;

    // (a + k) mod NREQ for a < NREQ and 0 <= k < NREQ
    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= NREQ) s = s - NREQ;
        return GW'(s);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] idx);
        logic [NREQ-1:0] one;
        one = {{(NREQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // Scan from the highest offset down so the requester closest to ptr wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[wrap_add(ptr, k)]) begin
                sel_valid = 1'b1;
                sel_idx   = wrap_add(ptr, k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            g       <= '0;
            ptr     <= '0;
            grant_r <= '0;
            fin_r   <= '0;
            rstn_r  <= '1;
            start_r <= '0;
`ifdef DRAW_ARB_WATCHDOG_EN
            to_r     <= '0;
            wdog_cnt <= '0;
`endif
        end else begin
            // End-of-draw pulses last a single cycle.
            fin_r <= '0;
`ifdef DRAW_ARB_WATCHDOG_EN
            to_r  <= '0;
`endif
            case (state)
                S_IDLE: begin
                    if (sel_valid) begin
                        g       <= sel_idx;
                        grant_r <= onehot(sel_idx);
                        rstn_r  <= ~onehot(sel_idx);
                        state   <= S_PREP;
                    end
                end
                S_PREP: begin
                    // Engine spent one cycle in reset and has re-latched its geometry.
                    rstn_r  <= '1;
                    start_r <= onehot(g);
                    state   <= S_RUN;
`ifdef DRAW_ARB_WATCHDOG_EN
                    wdog_cnt <= '0;
`endif
                end
                S_RUN: begin
                    if (bus.eng_done[g]) begin
                        start_r <= '0;
                        fin_r   <= onehot(g);
                        state   <= S_RELEASE;
                    end
`ifdef DRAW_ARB_WATCHDOG_EN
                    // Counter holds the number of RUN cycles already elapsed.
                    else if (wdog_cnt == 16'(WDOG_CYCLES - 1)) begin
                        start_r <= '0;
                        to_r    <= onehot(g);
                        state   <= S_RELEASE;
                    end else begin
                        wdog_cnt <= wdog_cnt + 16'd1;
                    end
`endif
                end
                S_RELEASE: begin
                    ptr     <= wrap_add(g, 1);
                    grant_r <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Pixel mux: only the running owner reaches the adapter.
    always_comb begin
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;
        bus.vga_plot   = 1'b0;
        if (state == S_RUN) begin
            bus.vga_x      = bus.eng_x[int'(g)*8 +: 8];
            bus.vga_y      = bus.eng_y[int'(g)*7 +: 7];
            bus.vga_colour = bus.eng_colour[int'(g)*3 +: 3];
            bus.vga_plot   = bus.eng_plot[g];
        end
    end

    assign bus.grant     = grant_r;
    assign bus.finished  = fin_r;
    assign bus.eng_rst_n = rstn_r;
    assign bus.eng_start = start_r;
    assign bus.busy      = (state != S_IDLE);
`ifdef DRAW_ARB_WATCHDOG_EN
    assign bus.timeout   = to_r;
`else
    assign bus.timeout   = '0;
`endif
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb/tb_vga_draw_arbiter.sv - self-checking bench for vga_draw_arbiter
module tb_vga_draw_arbiter;
    localparam int NREQ = 3;
    localparam int MLEN = 4;
`ifdef DRAW_ARB_WATCHDOG_EN
    localparam int WDOG = 20;
`else
    localparam int WDOG = 65535;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_draw_arbiter_if #(.NREQ(NREQ)) bus ();

    vga_draw_arbiter #(.NREQ(NREQ), .WDOG_CYCLES(WDOG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Engine pixel fields: eng0 45/30/5, eng1 12/100/3, eng2 99/99/7
    assign bus.eng_x      = {8'd99, 8'd12, 8'd45};
    assign bus.eng_y      = {7'd99, 7'd100, 7'd30};
    assign bus.eng_colour = {3'd7, 3'd3, 3'd5};
    assign bus.eng_plot   = 3'b111;

    int ex [3] = '{45, 12, 99};
    int ey [3] = '{30, 100, 99};
    int ec [3] = '{5, 3, 7};

    // Engine model: counts RUN cycles since its reset, asserts done after MLEN.
    logic       use_model;
    logic [2:0] tbl_done;
    logic [2:0] model_done;
    logic [7:0] mcnt [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!bus.eng_rst_n[i]) mcnt[i] <= 8'd0;
            else if (bus.eng_start[i]) mcnt[i] <= mcnt[i] + 8'd1;
        end
    end

    always_comb begin
        model_done = '0;
        for (int i = 0; i < 3; i++)
            model_done[i] = bus.eng_start[i] && (mcnt[i] >= 8'(MLEN));
    end

    assign bus.eng_done = use_model ? model_done : tbl_done;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] req;
        logic [2:0] done;
        int         rep;
        logic [2:0] grant;
        logic [2:0] rstn;
        logic [2:0] start;
        logic [2:0] fin;
        logic       busy;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       plot;
    } vec_t;

    vec_t tbl [8];

    logic [2:0] got [5];
    int         fin_cnt [3];
    int         n, gap, runs;
    logic       seen_run, dropped, found;
    logic [2:0] prev_grant, prev_start;

    initial begin
        tbl[0] = '{3'b010, 3'b000, 1,  3'b010, 3'b101, 3'b000, 3'b000, 1'b1, 8'd0,  7'd0,   3'd0, 1'b0};
        tbl[1] = '{3'b010, 3'b000, 10, 3'b010, 3'b111, 3'b010, 3'b000, 1'b1, 8'd12, 7'd100, 3'd3, 1'b1};
        tbl[2] = '{3'b010, 3'b010, 1,  3'b010, 3'b111, 3'b000, 3'b010, 1'b1, 8'd0,  7'd0,   3'd0, 1'b0};
        tbl[3] = '{3'b000, 3'b000, 2,  3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 8'd0,  7'd0,   3'd0, 1'b0};
        tbl[4] = '{3'b001, 3'b000, 1,  3'b001, 3'b110, 3'b000, 3'b000, 1'b1, 8'd0,  7'd0,   3'd0, 1'b0};
        tbl[5] = '{3'b001, 3'b100, 3,  3'b001, 3'b111, 3'b001, 3'b000, 1'b1, 8'd45, 7'd30,  3'd5, 1'b1};
        tbl[6] = '{3'b000, 3'b001, 1,  3'b001, 3'b111, 3'b000, 3'b001, 1'b1, 8'd0,  7'd0,   3'd0, 1'b0};
        tbl[7] = '{3'b000, 3'b000, 1,  3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 8'd0,  7'd0,   3'd0, 1'b0};

        rst_n     = 1'b0;
        bus.req   = '0;
        tbl_done  = '0;
        use_model = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", bus.grant, 0);
        chk("rst_eng_rst_n", bus.eng_rst_n, 3'b111);
        chk("rst_start", bus.eng_start, 0);
        chk("rst_finished", bus.finished, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_vga_plot", bus.vga_plot, 0);
        rst_n = 1'b1;

        // Single request, pixel mux, non-granted done ignored, req dropped mid-RUN
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                bus.req  = tbl[i].req;
                tbl_done = tbl[i].done;
                @(posedge clk);
                #1;
                chk($sformatf("row%0d_%0d_grant", i, r), bus.grant, tbl[i].grant);
                chk($sformatf("row%0d_%0d_eng_rst_n", i, r), bus.eng_rst_n, tbl[i].rstn);
                chk($sformatf("row%0d_%0d_start", i, r), bus.eng_start, tbl[i].start);
                chk($sformatf("row%0d_%0d_finished", i, r), bus.finished, tbl[i].fin);
                chk($sformatf("row%0d_%0d_busy", i, r), bus.busy, tbl[i].busy);
                chk($sformatf("row%0d_%0d_vga_x", i, r), bus.vga_x, tbl[i].x);
                chk($sformatf("row%0d_%0d_vga_y", i, r), bus.vga_y, tbl[i].y);
                chk($sformatf("row%0d_%0d_vga_colour", i, r), bus.vga_colour, tbl[i].col);
                chk($sformatf("row%0d_%0d_vga_plot", i, r), bus.vga_plot, tbl[i].plot);
                chk($sformatf("row%0d_%0d_timeout", i, r), bus.timeout, 0);
            end
        end

        // Reset returns rr pointer to 0, then round robin with all requests held
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        use_model  = 1'b1;
        bus.req    = 3'b111;
        n          = 0;
        gap        = 0;
        seen_run   = 1'b0;
        dropped    = 1'b0;
        prev_grant = '0;
        prev_start = '0;
        for (int i = 0; i < 3; i++) fin_cnt[i] = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.grant != 0 && prev_grant == 0) begin
                if (n < 5) got[n] = bus.grant;
                n++;
            end
            if (bus.eng_start != 0 && prev_start == 0) begin
                if (seen_run) chk("rr_gap", gap, 3);
                seen_run = 1'b1;
                gap      = 0;
            end
            if (bus.eng_start == 0 && seen_run) gap++;
            chk("start_within_grant", bus.eng_start & ~bus.grant, 0);
            if (bus.eng_start == 0) begin
                chk("idle_vga_plot", bus.vga_plot, 0);
            end
            for (int i = 0; i < 3; i++) begin
                if (bus.eng_start == 3'(1 << i)) begin
                    chk("rr_vga_x", bus.vga_x, ex[i]);
                    chk("rr_vga_y", bus.vga_y, ey[i]);
                    chk("rr_vga_colour", bus.vga_colour, ec[i]);
                    chk("rr_vga_plot", bus.vga_plot, 1);
                end
            end
            if (bus.finished != 0) begin
                chk("fin_owner", bus.finished, bus.grant);
                for (int i = 0; i < 3; i++) fin_cnt[i] += int'(bus.finished[i]);
            end
            if (n == 4 && bus.eng_start == 3'b001 && !dropped) begin
                bus.req = 3'b010;
                dropped = 1'b1;
            end
            if (n == 5 && bus.eng_start == 3'b010) bus.req = 3'b000;
            if (n == 5 && !bus.busy && bus.req == 0) break;
            prev_grant = bus.grant;
            prev_start = bus.eng_start;
        end
        chk("rr_grant_count", n, 5);
        chk("rr_grant0", got[0], 3'b001);
        chk("rr_grant1", got[1], 3'b010);
        chk("rr_grant2", got[2], 3'b100);
        chk("rr_grant3", got[3], 3'b001);
        chk("drop_then_grant1", got[4], 3'b010);
        chk("fin_cnt0", fin_cnt[0], 2);
        chk("fin_cnt1", fin_cnt[1], 2);
        chk("fin_cnt2", fin_cnt[2], 1);
        chk("rr_end_busy", bus.busy, 0);

        // Reset mid-draw on engine 2
        bus.req = 3'b100;
        found   = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.eng_start[2]) found = 1'b1;
        end
        chk("mid_rst_run_reached", found, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_grant", bus.grant, 0);
        chk("mid_rst_start", bus.eng_start, 0);
        chk("mid_rst_vga_plot", bus.vga_plot, 0);
        chk("mid_rst_finished", bus.finished, 0);
        chk("mid_rst_busy", bus.busy, 0);
        rst_n   = 1'b1;
        bus.req = 3'b101;
        @(posedge clk);
        #1;
        chk("post_rst_grant", bus.grant, 3'b001);
        chk("post_rst_finished", bus.finished, 0);
        bus.req = 3'b000;
        found   = 1'b0;
        for (int cyc = 0; cyc < 30 && !found; cyc++) begin
            @(posedge clk);
            #1;
            if (!bus.busy) found = 1'b1;
        end
        chk("post_rst_drain", found, 1);

`ifdef DRAW_ARB_WATCHDOG_EN
        // Engine never finishes: watchdog aborts after WDOG RUN cycles
        use_model = 1'b0;
        tbl_done  = '0;
        bus.req   = 3'b011;
        found     = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.eng_start[1]) found = 1'b1;
        end
        chk("wd_run_reached", found, 1);
        runs  = 1;
        found = 1'b0;
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.timeout != 0) found = 1'b1;
            else if (bus.eng_start[1]) runs++;
        end
        chk("wd_fired", found, 1);
        chk("wd_run_cycles", runs, 20);
        chk("wd_timeout", bus.timeout, 3'b010);
        chk("wd_finished", bus.finished, 0);
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.grant != 0) found = 1'b1;
        end
        chk("wd_next_grant", bus.grant, 3'b001);
        bus.req = 3'b000;
        found   = 1'b0;
        for (int cyc = 0; cyc < 60 && !found; cyc++) begin
            @(posedge clk);
            #1;
            if (!bus.busy) found = 1'b1;
        end
        chk("wd_drain", found, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
